// File: rtl/iomem_gpio_pkg.sv
// rtl/iomem_gpio_pkg.sv - register offsets and bus helpers for the iomem GPIO block
package iomem_gpio_pkg;

    localparam logic [7:0] GPIO_OUT     = 8'h00;
    localparam logic [7:0] GPIO_IN      = 8'h04;
    localparam logic [7:0] GPIO_DIR     = 8'h08;
    localparam logic [7:0] GPIO_RISE_EN = 8'h0C;
    localparam logic [7:0] GPIO_FALL_EN = 8'h10;
    localparam logic [7:0] GPIO_STATUS  = 8'h14;
    localparam logic [7:0] GPIO_INV     = 8'h18;

    typedef enum logic [2:0] {
        SEL_OUT,
        SEL_IN,
        SEL_DIR,
        SEL_RISE,
        SEL_FALL,
        SEL_STATUS,
        SEL_INV,
        SEL_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode_offset(input logic [7:0] off);
        reg_sel_e sel;
        case (off)
            GPIO_OUT:     sel = SEL_OUT;
            GPIO_IN:      sel = SEL_IN;
            GPIO_DIR:     sel = SEL_DIR;
            GPIO_RISE_EN: sel = SEL_RISE;
            GPIO_FALL_EN: sel = SEL_FALL;
            GPIO_STATUS:  sel = SEL_STATUS;
            GPIO_INV:     sel = SEL_INV;
            default:      sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] strobe_mask(input logic [3:0] wstrb);
        return {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - per-pin synchroniser and tick-sampled 3-of-3 debouncer
module gpio_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] deb_o
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] deb_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    deb_q <= '0;
                end else begin
                    deb_q <= sync2_q;
                end
            end
        end else begin : g_filter
            localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0]    cnt_q, cnt_d;
            logic [WIDTH-1:0] hist0_q, hist0_d;
            logic [WIDTH-1:0] hist1_q, hist1_d;
            logic [WIDTH-1:0] deb_d;
            logic [WIDTH-1:0] agree;
            logic             tick;

            always_comb begin
                tick    = (cnt_q == LAST);
                cnt_d   = tick ? '0 : cnt_q + CW'(1);
                hist0_d = hist0_q;
                hist1_d = hist1_q;
                deb_d   = deb_q;
                // A pin only moves once three consecutive tick samples agree.
                agree   = ~(sync2_q ^ hist0_q) & ~(sync2_q ^ hist1_q);
                if (tick) begin
                    hist0_d = sync2_q;
                    hist1_d = hist0_q;
                    deb_d   = (deb_q & ~agree) | (sync2_q & agree);
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    cnt_q   <= '0;
                    hist0_q <= '0;
                    hist1_q <= '0;
                    deb_q   <= '0;
                end else begin
                    cnt_q   <= cnt_d;
                    hist0_q <= hist0_d;
                    hist1_q <= hist1_d;
                    deb_q   <= deb_d;
                end
            end
        end
    endgenerate

    assign deb_o = deb_q;

endmodule

// File: rtl/iomem_gpio.sv
// rtl/iomem_gpio.sv - PicoSoC iomem GPIO with direction, inversion, debounce and edge irq
module iomem_gpio
    import iomem_gpio_pkg::*;
#(
    parameter int         WIDTH           = 8,
    parameter logic [7:0] ADDR_BASE       = 8'h03,
    parameter int         DEBOUNCE_CYCLES = 16000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    output logic             irq
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] inv_q, inv_d;
    logic [WIDTH-1:0] lvl_q;
    logic             ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] lvl;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] mask_w;
    logic [WIDTH-1:0] wdata_w;
    logic             sel;
    logic             wr;
    reg_sel_e         rsel;
    logic             unused_bus;

    gpio_debounce #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .resetn (resetn),
        .pin_i  (pin_in),
        .deb_o  (deb)
    );

    function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_v,
                                                     input logic [WIDTH-1:0] new_v,
                                                     input logic [WIDTH-1:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    // Address bits 23:8 and data bits above WIDTH are don't-care by design.
    assign unused_bus = ^{iomem_addr[23:8], iomem_wdata};

    always_comb begin
        sel      = iomem_valid && !ready_q && (iomem_addr[31:24] == ADDR_BASE);
        wr       = sel && (iomem_wstrb != 4'b0000);
        rsel     = decode_offset(iomem_addr[7:0]);
        mask_w   = WIDTH'(strobe_mask(iomem_wstrb));
        wdata_w  = iomem_wdata[WIDTH-1:0];

        out_d    = out_q;
        dir_d    = dir_q;
        rise_d   = rise_q;
        fall_d   = fall_q;
        inv_d    = inv_q;
        w1c      = '0;
        rd_val   = '0;

        lvl      = deb ^ inv_q;
        edge_set = (lvl & ~lvl_q & rise_q) | (~lvl & lvl_q & fall_q);

        case (rsel)
            SEL_OUT:    rd_val = out_q;
            SEL_IN:     rd_val = lvl;
            SEL_DIR:    rd_val = dir_q;
            SEL_RISE:   rd_val = rise_q;
            SEL_FALL:   rd_val = fall_q;
            SEL_STATUS: rd_val = status_q;
            SEL_INV:    rd_val = inv_q;
            default:    rd_val = '0;
        endcase

        if (wr) begin
            case (rsel)
                SEL_OUT:    out_d  = merge_bytes(out_q, wdata_w, mask_w);
                SEL_DIR:    dir_d  = merge_bytes(dir_q, wdata_w, mask_w);
                SEL_RISE:   rise_d = merge_bytes(rise_q, wdata_w, mask_w);
                SEL_FALL:   fall_d = merge_bytes(fall_q, wdata_w, mask_w);
                SEL_INV:    inv_d  = merge_bytes(inv_q, wdata_w, mask_w);
                SEL_STATUS: w1c    = wdata_w & mask_w;
                default:    ;
            endcase
        end

        // Clear first, then set: a new edge survives a simultaneous W1C.
        status_d = (status_q & ~w1c) | edge_set;
        ready_d  = sel;
        rdata_d  = sel ? 32'(rd_val) : 32'd0;
        irq_d    = |status_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_q    <= '0;
            dir_q    <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            status_q <= '0;
            inv_q    <= '0;
            lvl_q    <= '0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            out_q    <= out_d;
            dir_q    <= dir_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            status_q <= status_d;
            inv_q    <= inv_d;
            lvl_q    <= lvl;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    assign pin_out     = out_q;
    assign pin_oe      = dir_q;
    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign irq         = irq_q;

endmodule
